const_burst_source: RTL

CONST_BURST_SOURCE -- requirements
Module: const_burst_source

---
 rtl/const_burst_source.sv | 102 ++++++++++
 1 files changed

// File: rtl/const_burst_source.sv
`default_nettype none
// ============================================================================
// Module  : const_burst_source
// Brief   : Emits a counted burst of a loadable constant word over a
//           valid/ready handshake, with a one-cycle done pulse on completion.
// Revision: 1.0 - initial release
// ============================================================================
module const_burst_source #(
    parameter int unsigned      WIDTH = 1,
    parameter logic [WIDTH-1:0] VALUE = WIDTH'(1),
    parameter int unsigned      CW    = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_one = CW'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_remaining;
    logic [CW-1:0]    w_remaining_next;
    logic [WIDTH-1:0] r_const;
    logic [WIDTH-1:0] w_const_next;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_const     <= VALUE;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_const     <= w_const_next;
        end
    end

    // Outputs are decoded from state alone, so reset clears them immediately.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_const_next     = r_const;
        load_ready       = 1'b0;
        O_valid          = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load) begin
                    w_const_next = load_data;
                end
                if (start) begin
                    if (count != '0) begin
                        w_state_next     = S_RUN;
                        w_remaining_next = count;
                    end else begin
                        w_state_next = S_FIN;
                    end
                end
            end
            S_RUN: begin
                O_valid = 1'b1;
                busy    = 1'b1;
                if (O_ready) begin
                    w_remaining_next = r_remaining - c_one;
                    if (r_remaining == c_one) begin
                        w_state_next = S_FIN;
                    end
                end
            end
            S_FIN: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign O = r_const;

endmodule
`default_nettype wire
